// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - MEM/WB writeback stage: register file, flags, halt latch and commit counter
module wb_regfile #(
    parameter int DW   = 16,
    parameter int NREG = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [59:0]   wb_bus,
    input  logic [3:0]    rd_addr_a,
    input  logic [3:0]    rd_addr_b,
    output logic [DW-1:0] rd_data_a,
    output logic [DW-1:0] rd_data_b,
    output logic [2:0]    flags_q,
    output logic [DW-1:0] wb_data,
    output logic          wb_en,
    output logic          halted,
    output logic [15:0]   wb_count
);

    // Bus field decode
    logic [2:0]    bus_flags;
    logic [DW-1:0] bus_alu_out;
    logic [DW-1:0] bus_mem_out;
    logic [3:0]    bus_dst_reg;
    logic          bus_mem_to_reg;
    logic          bus_reg_write;
    logic          bus_reg_write_sel;
    logic [DW-1:0] bus_pc_plus2;
    logic          bus_flag_write;
    logic          bus_halt;

    assign bus_flags         = wb_bus[2:0];
    assign bus_alu_out       = wb_bus[18:3];
    assign bus_mem_out       = wb_bus[34:19];
    assign bus_dst_reg       = wb_bus[38:35];
    assign bus_mem_to_reg    = wb_bus[39];
    assign bus_reg_write     = wb_bus[40];
    assign bus_reg_write_sel = wb_bus[41];
    assign bus_pc_plus2      = wb_bus[57:42];
    assign bus_flag_write    = wb_bus[58];
    assign bus_halt          = wb_bus[59];

    // Architectural state
    logic [DW-1:0] regs_q [NREG];
    logic [2:0]    flags_d;
    logic          halted_q;
    logic          halted_d;
    logic [15:0]   wb_count_q;
    logic [15:0]   wb_count_d;

    assign halted   = halted_q;
    assign wb_count = wb_count_q;

    // Writeback data select: link address beats memory data beats ALU result
    always_comb begin
        wb_data = bus_alu_out;
        if (bus_reg_write_sel) begin
            wb_data = bus_pc_plus2;
        end else if (bus_mem_to_reg) begin
            wb_data = bus_mem_out;
        end
    end

    // R0 is hardwired to zero, so writes to it never qualify
    assign wb_en = bus_reg_write & ~halted_q & (bus_dst_reg != 4'd0);

    // Next-state for flags, halt latch and commit counter; frozen once halted
    always_comb begin
        flags_d    = flags_q;
        halted_d   = halted_q;
        wb_count_d = wb_count_q;
        if (!halted_q) begin
            if (bus_flag_write) begin
                flags_d = bus_flags;
            end
            if (bus_halt) begin
                halted_d = 1'b1;
            end
        end
        if (wb_en) begin
            wb_count_d = wb_count_q + 16'd1;
        end
    end

    // Read port A with write-before-read bypass
    always_comb begin
        rd_data_a = regs_q[rd_addr_a];
        if (rd_addr_a == 4'd0) begin
            rd_data_a = '0;
        end else if (wb_en && (rd_addr_a == bus_dst_reg)) begin
            rd_data_a = wb_data;
        end
    end

    // Read port B with write-before-read bypass
    always_comb begin
        rd_data_b = regs_q[rd_addr_b];
        if (rd_addr_b == 4'd0) begin
            rd_data_b = '0;
        end else if (wb_en && (rd_addr_b == bus_dst_reg)) begin
            rd_data_b = wb_data;
        end
    end

    // Register file write; the halting word itself still commits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_en) begin
            regs_q[bus_dst_reg] <= wb_data;
        end
    end

    // Flags, halt latch and commit counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flags_q    <= 3'b000;
            halted_q   <= 1'b0;
            wb_count_q <= 16'd0;
        end else begin
            flags_q    <= flags_d;
            halted_q   <= halted_d;
            wb_count_q <= wb_count_d;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - directed table-driven bench for wb_regfile
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic [59:0] wb_bus;
    logic [3:0]  rd_addr_a;
    logic [3:0]  rd_addr_b;
    logic [15:0] rd_data_a;
    logic [15:0] rd_data_b;
    logic [2:0]  flags_q;
    logic [15:0] wb_data;
    logic        wb_en;
    logic        halted;
    logic [15:0] wb_count;

    int checks;
    int errors;

    wb_regfile #(.DW(16), .NREG(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_bus    (wb_bus),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .flags_q   (flags_q),
        .wb_data   (wb_data),
        .wb_en     (wb_en),
        .halted    (halted),
        .wb_count  (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [59:0] bus;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic        exp_en;
        logic [15:0] exp_data;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        logic [2:0]  exp_flags;
        logic        exp_halt;
        logic [15:0] exp_cnt;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    function automatic logic [59:0] mkbus(input logic halt, input logic fw, input logic rws,
                                          input logic rw, input logic mtr, input logic [3:0] dst,
                                          input logic [15:0] alu, input logic [15:0] mem,
                                          input logic [15:0] pc, input logic [2:0] fl);
        return {halt, fw, pc, rws, rw, mtr, dst, mem, alu, fl};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        wb_bus    = '0;
        rd_addr_a = 4'd3;
        rd_addr_b = 4'd5;

        //                halt fw rws rw mtr dst    alu       mem       pc        fl          ra  rb   en  data      a         b         flags   h  cnt
        vecs[0]  = '{mkbus(0, 0, 0, 1, 0, 4'd0, 16'h1234, 16'h0000, 16'h0000, 3'b000), 4'd0, 4'd0, 0, 16'h1234, 16'h0000, 16'h0000, 3'b000, 0, 16'd0};
        vecs[1]  = '{mkbus(0, 0, 0, 1, 0, 4'd3, 16'h00AA, 16'h00BB, 16'h00CC, 3'b000), 4'd3, 4'd0, 1, 16'h00AA, 16'h00AA, 16'h0000, 3'b000, 0, 16'd1};
        vecs[2]  = '{mkbus(0, 0, 0, 1, 1, 4'd3, 16'h00AA, 16'h00BB, 16'h00CC, 3'b000), 4'd4, 4'd3, 1, 16'h00BB, 16'h0000, 16'h00BB, 3'b000, 0, 16'd2};
        vecs[3]  = '{mkbus(0, 0, 1, 1, 1, 4'd3, 16'h00AA, 16'h00BB, 16'h00CC, 3'b000), 4'd3, 4'd3, 1, 16'h00CC, 16'h00CC, 16'h00CC, 3'b000, 0, 16'd3};
        vecs[4]  = '{mkbus(0, 0, 0, 0, 0, 4'd3, 16'h0000, 16'h0000, 16'h0000, 3'b000), 4'd3, 4'd0, 0, 16'h0000, 16'h00CC, 16'h0000, 3'b000, 0, 16'd3};
        vecs[5]  = '{mkbus(0, 0, 0, 1, 0, 4'd5, 16'hBEEF, 16'h0000, 16'h0000, 3'b000), 4'd5, 4'd5, 1, 16'hBEEF, 16'hBEEF, 16'hBEEF, 3'b000, 0, 16'd4};
        vecs[6]  = '{mkbus(0, 0, 0, 0, 0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 3'b000), 4'd5, 4'd5, 0, 16'h0000, 16'hBEEF, 16'hBEEF, 3'b000, 0, 16'd4};
        vecs[7]  = '{mkbus(0, 1, 0, 0, 0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 3'b101), 4'd3, 4'd5, 0, 16'h0000, 16'h00CC, 16'hBEEF, 3'b101, 0, 16'd4};
        vecs[8]  = '{mkbus(0, 0, 0, 0, 0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 3'b010), 4'd3, 4'd5, 0, 16'h0000, 16'h00CC, 16'hBEEF, 3'b101, 0, 16'd4};
        vecs[9]  = '{mkbus(1, 1, 0, 1, 0, 4'd7, 16'h0007, 16'h0000, 16'h0000, 3'b110), 4'd7, 4'd5, 1, 16'h0007, 16'h0007, 16'hBEEF, 3'b110, 1, 16'd5};
        vecs[10] = '{mkbus(0, 1, 0, 1, 0, 4'd7, 16'h0070, 16'h0000, 16'h0000, 3'b111), 4'd7, 4'd3, 0, 16'h0070, 16'h0007, 16'h00CC, 3'b110, 1, 16'd5};
        vecs[11] = '{mkbus(0, 0, 0, 0, 0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 3'b000), 4'd7, 4'd3, 0, 16'h0000, 16'h0007, 16'h00CC, 3'b110, 1, 16'd5};

        // Reset state
        #12;
        chk("reset_rd_a",   rd_data_a, 16'h0000);
        chk("reset_rd_b",   rd_data_b, 16'h0000);
        chk("reset_flags",  {13'd0, flags_q}, 16'h0000);
        chk("reset_halted", {15'd0, halted}, 16'h0000);
        chk("reset_count",  wb_count, 16'h0000);
        @(negedge clk);
        rst = 1'b1;

        // Vector table: combinational outputs before the edge, state after it
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            wb_bus    = vecs[i].bus;
            rd_addr_a = vecs[i].ra;
            rd_addr_b = vecs[i].rb;
            #1;
            chk($sformatf("v%0d_wb_en", i),   {15'd0, wb_en}, {15'd0, vecs[i].exp_en});
            chk($sformatf("v%0d_wb_data", i), wb_data, vecs[i].exp_data);
            chk($sformatf("v%0d_rd_a", i),    rd_data_a, vecs[i].exp_a);
            chk($sformatf("v%0d_rd_b", i),    rd_data_b, vecs[i].exp_b);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_flags", i),  {13'd0, flags_q}, {13'd0, vecs[i].exp_flags});
            chk($sformatf("v%0d_halted", i), {15'd0, halted}, {15'd0, vecs[i].exp_halt});
            chk($sformatf("v%0d_count", i),  wb_count, vecs[i].exp_cnt);
        end

        // Asynchronous reset mid-cycle, away from any clock edge
        @(negedge clk);
        wb_bus    = '0;
        rd_addr_a = 4'd7;
        rd_addr_b = 4'd3;
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_rd_a",   rd_data_a, 16'h0000);
        chk("midrst_rd_b",   rd_data_b, 16'h0000);
        chk("midrst_flags",  {13'd0, flags_q}, 16'h0000);
        chk("midrst_halted", {15'd0, halted}, 16'h0000);
        chk("midrst_count",  wb_count, 16'h0000);
        rd_addr_a = 4'd5;
        #1;
        chk("midrst_r5", rd_data_a, 16'h0000);
        @(negedge clk);
        rst = 1'b1;

        // Repeated word rewrites and counts again; then run the counter round to wrap
        for (int i = 0; i < 65536; i++) begin
            @(negedge clk);
            wb_bus    = mkbus(0, 0, 0, 1, 0, 4'd1, i[15:0], 16'h0000, 16'h0000, 3'b000);
            rd_addr_a = 4'd1;
            rd_addr_b = 4'd0;
            if (i == 65535) begin
                #1;
                chk("wrap_pre_count", wb_count, 16'hFFFF);
            end
        end
        @(negedge clk);
        wb_bus = '0;
        #1;
        chk("wrap_count", wb_count, 16'h0000);
        chk("wrap_r1",    rd_data_a, 16'hFFFF);
        chk("wrap_r0",    rd_data_b, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback-side consumer of the 60-bit MEM/WB pipeline bus.
- Decodes the bus fields and selects the writeback data.
- Owns the 16x16 architectural register file and the 3-bit flag register (Z,V,N).
- Provides two decode-stage read ports with same-cycle write bypass, and latches HLT so the core stops retiring.

Parameters:
- DW, 16, data/register width
- NREG, 16, number of architectural registers; register index width is 4

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- wb_bus  in  60  MEM/WB register Q output. Field map:
  - [2:0] flags {N,V,Z} = {2,1,0}
  - [18:3] alu_out
  - [34:19] mem_out
  - [38:35] dst_reg
  - [39] mem_to_reg
  - [40] reg_write
  - [41] reg_write_sel
  - [57:42] pc_plus2
  - [58] flag_write
  - [59] halt
- rd_addr_a  in  4  decode read port A index
- rd_addr_b  in  4  decode read port B index
- rd_data_a  out  16  port A data
- rd_data_b  out  16  port B data
- flags_q  out  3  architectural flags {N,V,Z}
- wb_data  out  16  selected writeback value, exported for forwarding
- wb_en  out  1  qualified register write this cycle
- halted  out  1  sticky halt indicator
- wb_count  out  16  count of committed register writes

Behaviour:
- Reset (rst=0, async, takes effect immediately, also mid-operation):
  - all 16 registers = 0, flags_q = 0, halted = 0, wb_count = 0.
  - Combinational outputs follow from the cleared state and the current wb_bus.
- Writeback data select (combinational):
  - reg_write_sel=1 -> pc_plus2
  - else mem_to_reg=1 -> mem_out
  - else alu_out
- wb_en = reg_write & ~halted & (dst_reg != 0).
  - R0 is hardwired to 0; writes to it are dropped and it always reads 0.
- Register write: on the rising edge with wb_en=1, reg[dst_reg] <= wb_data.
  - Latency: one edge; the value is architecturally visible from the next cycle.
- Read ports (combinational):
  - rd_data_x = 0 if rd_addr_x == 0.
  - else wb_data if wb_en and rd_addr_x == dst_reg (write-before-read bypass).
  - else reg[rd_addr_x].
  - Both ports bypass independently; identical addresses on A and B are legal.
- Flag register: on the rising edge with flag_write=1 and halted=0, flags_q <= wb_bus[2:0]. All three bits update together; there is no partial update.
- A single bus word may carry both reg_write and flag_write; both commit on the same edge.
- Halt:
  - on the rising edge with halt=1 and halted=0, halted <= 1.
  - The halting word's own reg_write and flag_write still commit on that edge.
  - Once halted=1, every later word is ignored: no register, flag or counter updates.
  - halted clears only on reset.
- wb_count: increments by 1 on each edge where wb_en=1. Width 16, wraps 0xFFFF -> 0x0000 with no flag.
- A bus word with reg_write=0, flag_write=0 and halt=0 (bubble) changes no state.
- No internal stall: the block consumes one bus word per cycle. Hold-off is done upstream through the MEM/WB register write enable, which presents a repeated word. A repeated word with reg_write=1 rewrites the same value and increments wb_count again.

Test Plan:
- Reset and R0:
  - Stimulus: assert rst=0 mid-run, then release. Then send reg_write=1, dst=0, alu_out=0x1234.
  - Required response: during reset all reads, flags_q, wb_count and halted are 0. After the write, reading R0 returns 0, wb_en=0 and wb_count stays 0.
- Data select:
  - Stimulus: three words to R3 with alu=0x00AA, mem=0x00BB, pc_plus2=0x00CC, using (sel=0,mtr=0), (sel=0,mtr=1), (sel=1,mtr=x).
  - Required response: R3 reads 0x00AA, then 0x00BB, then 0x00CC on successive cycles; wb_count = 3.
- Bypass:
  - Stimulus: write R5=0xBEEF with rd_addr_a=5 and rd_addr_b=5 in the same cycle.
  - Required response: both ports show 0xBEEF before the edge, and still 0xBEEF after it with the bus idle.
- Flags:
  - Stimulus: flag_write=1, flags=3'b101. Next word: flag_write=0, flags=3'b010.
  - Required response: flags_q = 3'b101 and stays 3'b101.
- Halt:
  - Stimulus: word with halt=1, reg_write=1, R7=0x0007. Then a word writing R7=0x0070 with flag_write=1, flags=3'b111.
  - Required response: R7=0x0007, halted=1, flags_q unchanged, wb_count incremented once only.
- Counter wrap:
  - Stimulus: 65536 consecutive writes to R1.
  - Required response: wb_count returns to 0x0000.
